// File: rtl/aes_pkg.sv
// AES key-schedule shared definitions: round counts, FSM state type, word helpers.
// Latency: n/a (package: constants, types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int NUM_ROUNDS_128 = 10;
    localparam int NUM_ROUND_KEYS = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } kg_state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Cyclic rotate of a word left by one byte: [a0,a1,a2,a3] -> [a1,a2,a3,a0].
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sbox.sv
// SubWord: four parallel AES forward byte substitutions.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   sboxw      in  32  word to substitute
//   new_sboxw  out 32  SubWord(sboxw), byte-wise
module sbox (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign new_sboxw[31:24] = SBOX[sboxw[31:24]];
    assign new_sboxw[23:16] = SBOX[sboxw[23:16]];
    assign new_sboxw[15:8]  = SBOX[sboxw[15:8]];
    assign new_sboxw[7:0]   = SBOX[sboxw[7:0]];

endmodule

// File: rtl/aes_key_gen.sv
// AES-128 key expansion: 11 round keys, one new round key per clock.
// Latency: key_ready rises 10 clocks after the key_init rising edge; round_key read is
//          0 cycles, or 1 cycle when AES_KEY_GEN_REG_OUT_EN is defined (registered output).
// Backpressure: none; key_init edges arriving mid-expansion are ignored.
//
// Ports:
//   aclk, areset  clock, asynchronous active-high reset
//   key           128-bit cipher key (key[127:96] = w0), captured on the key_init rising edge
//   keylen        key length select, only AES-128 exists so it has no effect
//   key_init      expansion start, rising-edge sensitive
//   round         round-key read index 0..10 (11..15 read as zero)
//   round_key     selected round key, meaningful while key_ready is high
//   key_ready     all 11 round keys valid
//   sbox_feed     word driven to the external SubWord unit (zero outside expansion)
//   new_sbox      SubWord(sbox_feed) returned combinationally by the external unit
module aes_key_gen
    import aes_pkg::*;
(
    input  logic         aclk,
    input  logic         areset,
    input  logic [127:0] key,
    input  logic         keylen,
    input  logic         key_init,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         key_ready,
    output logic [31:0]  sbox_feed,
    input  logic [31:0]  new_sbox
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS_128);

    kg_state_t    state;
    kg_state_t    state_nxt;

    logic [127:0] mem [NUM_ROUND_KEYS];
    logic [3:0]   counter;
    logic [7:0]   rcon;
    logic         key_init_q;

    logic         init_rise;
    logic         load_key;
    logic         gen_step;
    logic         gen_last;

    logic [3:0]   prev_idx;
    logic [127:0] prev_key;
    logic [31:0]  t_word;
    logic [31:0]  w0_nxt;
    logic [31:0]  w1_nxt;
    logic [31:0]  w2_nxt;
    logic [31:0]  w3_nxt;
    logic [127:0] rk_sel;

    // Only one key length exists, so the select is intentionally ignored.
    logic         unused_keylen;
    assign unused_keylen = keylen;

    assign init_rise = key_init & ~key_init_q;
    assign gen_last  = (counter == LAST_IDX);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_key  = 1'b0;
        gen_step  = 1'b0;
        sbox_feed = 32'h0;
        unique case (state)
            IDLE, DONE: begin
                if (init_rise) begin
                    load_key  = 1'b1;
                    state_nxt = GEN;
                end
            end
            GEN: begin
                // New start requests are not honoured until the schedule completes.
                gen_step  = 1'b1;
                sbox_feed = prev_key[31:0];
                if (gen_last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // One key-schedule round: derive mem[counter] from mem[counter-1]
    // ------------------------------------------------------------------
    always_comb begin
        prev_idx = counter - 4'd1;
        prev_key = '0;
        if (prev_idx <= LAST_IDX) begin
            prev_key = mem[prev_idx];
        end
    end

    // SubWord and RotWord commute, so rotating the substituted word is exact.
    assign t_word = rot_word(new_sbox) ^ {rcon, 24'h0};
    assign w0_nxt = prev_key[127:96] ^ t_word;
    assign w1_nxt = prev_key[95:64]  ^ w0_nxt;
    assign w2_nxt = prev_key[63:32]  ^ w1_nxt;
    assign w3_nxt = prev_key[31:0]   ^ w2_nxt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            key_init_q <= 1'b0;
            counter    <= 4'd0;
            rcon       <= 8'h00;
            key_ready  <= 1'b0;
            for (int i = 0; i < NUM_ROUND_KEYS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            key_init_q <= key_init;
            if (load_key) begin
                mem[0]    <= key;
                rcon      <= 8'h01;
                counter   <= 4'd1;
                key_ready <= 1'b0;
            end else if (gen_step) begin
                mem[counter] <= {w0_nxt, w1_nxt, w2_nxt, w3_nxt};
                counter      <= counter + 4'd1;
                rcon         <= xtime(rcon);
                if (gen_last) begin
                    key_ready <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-key read port
    // ------------------------------------------------------------------
    always_comb begin
        rk_sel = '0;
        if (round <= LAST_IDX) begin
            rk_sel = mem[round];
        end
    end

`ifdef AES_KEY_GEN_REG_OUT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            round_key <= '0;
        end else begin
            round_key <= rk_sel;
        end
    end
`else
    assign round_key = rk_sel;
`endif

endmodule

// File: tb/tb_aes_key_gen.sv
// Self-checking bench for aes_key_gen with the sbox unit wired beside it.
// Reads are queued by the stimulus and scored by an independent negedge monitor.
// Reference keys come from a GF(2^8) model of the FIPS-197 key schedule.
module tb_aes_key_gen;

    logic         aclk = 1'b0;
    logic         areset;
    logic [127:0] key;
    logic         keylen;
    logic         key_init;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         key_ready;
    logic [31:0]  sbox_feed;
    logic [31:0]  new_sbox;

    int checks = 0;
    int errors = 0;

    logic         rd_vld   = 1'b0;
    logic         rd_vld_q = 1'b0;
    logic         chk_vld;
    logic [127:0] exp_q [$];
    int           exp_r_q [$];
    logic [127:0] mon_exp;
    int           mon_r;
    logic [127:0] ref_keys [11];

    always #5 aclk = ~aclk;

    aes_key_gen dut (
        .aclk      (aclk),
        .areset    (areset),
        .key       (key),
        .keylen    (keylen),
        .key_init  (key_init),
        .round     (round),
        .round_key (round_key),
        .key_ready (key_ready),
        .sbox_feed (sbox_feed),
        .new_sbox  (new_sbox)
    );

    sbox u_sbox (
        .sboxw     (sbox_feed),
        .new_sboxw (new_sbox)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        logic [7:0] inv, s, r;
        inv = 8'h00;
        for (int i = 1; i < 256; i++) begin
            if (a != 8'h00 && gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
        end
        s = inv; r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    task automatic compute_ref(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

`ifdef AES_KEY_GEN_REG_OUT_EN
    assign chk_vld = rd_vld_q;
`else
    assign chk_vld = rd_vld;
`endif

    always @(posedge aclk) rd_vld_q <= rd_vld;

    always @(negedge aclk) begin
        if (chk_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow got %h expected no output", round_key);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_r   = exp_r_q.pop_front();
                if (round_key !== mon_exp) begin
                    errors++;
                    $display("FAIL round_key[%0d] got %h expected %h", mon_r, round_key, mon_exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_read(input int r, input logic [127:0] exp);
        @(posedge aclk); #1;
        round  = 4'(r);
        rd_vld = 1'b1;
        exp_q.push_back(exp);
        exp_r_q.push_back(r);
    endtask

    task automatic end_reads;
        @(posedge aclk); #1;
        rd_vld = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("sb_drain", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic sweep_reads;
        for (int r = 0; r < 16; r++) issue_read(r, (r <= 10) ? ref_keys[r] : 128'h0);
    endtask

    task automatic start_exp(input logic [127:0] k, input logic kl, input int hold, input int glitch_at);
        int cycles;
        compute_ref(k);
        @(posedge aclk); #1;
        key = k; keylen = kl; key_init = 1'b1;
        @(posedge aclk); #1;                       // start edge
        if (hold <= 1) key_init = 1'b0;
        chk("ready_clear", 128'(key_ready), 128'd0);
        chk("sbox_feed_first", 128'(sbox_feed), 128'(k[31:0]));
        cycles = 0;
        while (key_ready !== 1'b1 && cycles < 20) begin
            if (cycles == glitch_at) begin
                key = ~k; key_init = 1'b1;
            end else if (glitch_at >= 0 && cycles == glitch_at + 1) begin
                key_init = 1'b0;
            end
            @(posedge aclk); #1;
            cycles++;
        end
        chk("ready_latency", 128'(cycles), 128'd10);
        if (hold > 1) begin
            repeat (hold - 11) @(posedge aclk);
            #1 key_init = 1'b0;
            chk("single_expansion", 128'(key_ready), 128'd1);
        end
        chk("sbox_feed_done", 128'(sbox_feed), 128'd0);
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] k;
        int           r;

        areset = 1'b1; key = '0; keylen = 1'b0; key_init = 1'b0; round = 4'd0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("reset_ready", 128'(key_ready), 128'd0);
        chk("reset_round_key", round_key, 128'h0);
        chk("reset_sbox_feed", 128'(sbox_feed), 128'd0);
        areset = 1'b0;
        repeat (3) @(negedge aclk);
        chk("idle_ready", 128'(key_ready), 128'd0);
        chk("idle_round_key", round_key, 128'h0);

        // FIPS-197 appendix key
        start_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1, -1);
        issue_read(1,  128'ha0fafe1788542cb123a339392a6c7605);
        issue_read(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sweep_reads();
        end_reads();

        // all-ones key, keylen=1, start held high for 25 cycles
        start_exp({128{1'b1}}, 1'b1, 25, -1);
        issue_read(0, {128{1'b1}});
        issue_read(1, 128'he8e9e9e917161616e8e9e9e917161616);
        sweep_reads();
        end_reads();

        // all-zero key
        start_exp(128'h0, 1'b0, 1, -1);
        issue_read(1,  128'h62636363626363636263636362636363);
        issue_read(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        issue_read(13, 128'h0);
        end_reads();

        // restart from DONE with a new key; a second edge mid-expansion is ignored
        start_exp(rand_key(), 1'b0, 1, 3);
        sweep_reads();
        end_reads();

        // reset during expansion
        k = rand_key();
        @(posedge aclk); #1;
        key = k; key_init = 1'b1;
        @(posedge aclk); #1;
        key_init = 1'b0;
        repeat (5) @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        chk("midgen_reset_ready", 128'(key_ready), 128'd0);
        chk("midgen_reset_round_key", round_key, 128'h0);
        chk("midgen_reset_sbox_feed", 128'(sbox_feed), 128'd0);
        #1 areset = 1'b0;
        repeat (12) @(posedge aclk);
        #1;
        chk("no_restart_ready", 128'(key_ready), 128'd0);
        chk("no_restart_sbox_feed", 128'(sbox_feed), 128'd0);
        start_exp(k, 1'b0, 1, -1);
        sweep_reads();
        end_reads();

        // random keys with random read order
        for (int n = 0; n < 3; n++) begin
            start_exp(rand_key(), 1'($urandom_range(0, 1)), 1, -1);
            for (int i = 0; i < 12; i++) begin
                r = $urandom_range(0, 15);
                issue_read(r, (r <= 10) ? ref_keys[r] : 128'h0);
            end
            end_reads();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
